// File: rtl/uart_rx_ctrl_if.sv
// Register-side bundle of uart_rx_ctrl: live line configuration, the read
// strobe, and the received character with its status flags.
interface uart_rx_ctrl_if;
   logic       data_bits;
   logic       parity_en;
   logic       parity_odd0_even1;
   logic       rx_data_read;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       parity_err;
   logic       framing_err;
   logic       overflow;

   modport master (
      output data_bits, parity_en, parity_odd0_even1, rx_data_read,
      input  rx_data, rx_ready, parity_err, framing_err, overflow
   );

   modport slave (
      input  data_bits, parity_en, parity_odd0_even1, rx_data_read,
      output rx_data, rx_ready, parity_err, framing_err, overflow
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive control: 16x oversampled deframer (start/7-8 data/parity/stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit decision.
module uart_rx_ctrl (
   input  logic          PCLK,
   input  logic          PRESETN,
   input  logic          rx_sample_pulse,
   input  logic          UART_RX,
   uart_rx_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state;
   logic       rx_p0, rx_s;
   logic [3:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
   logic       par_bit;
   logic       bit_v;
   logic       last_bit;
   logic       stop_done;
   logic [7:0] frame_data;

   function automatic logic parity_fail(input logic [7:0] d, input logic p,
                                        input logic even);
      return (^d ^ p) ^ ~even;
   endfunction

   // Two-flop synchronizer stage boundary; idles high like the line.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         rx_p0 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_p0 <= UART_RX;
         rx_s  <= rx_p0;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // The two previous pulse samples plus the current one form the vote window.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN)             hist <= 2'b11;
      else if (rx_sample_pulse) hist <= {hist[0], rx_s};
   end

   assign bit_v = maj3(hist[1], hist[0], rx_s);
`else
   assign bit_v = rx_s;
`endif

   assign last_bit   = (idx == (bus.data_bits ? 3'd7 : 3'd6));
   assign stop_done  = rx_sample_pulse && (state == STOP) && (cnt == 4'd15);
   assign frame_data = bus.data_bits ? shift : {1'b0, shift[7:1]};

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         idx             <= 3'd0;
         shift           <= 8'h00;
         par_bit         <= 1'b0;
         bus.rx_data     <= 8'h00;
         bus.rx_ready    <= 1'b0;
         bus.parity_err  <= 1'b0;
         bus.framing_err <= 1'b0;
         bus.overflow    <= 1'b0;
      end else begin
         if (rx_sample_pulse) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state <= START;
                     cnt   <= 4'd0;
                  end
               end
               START: begin
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     if (!bit_v) begin
                        state <= DATA;
                        cnt   <= 4'd0;
                        idx   <= 3'd0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               DATA: begin
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     shift <= {bit_v, shift[7:1]};
                     idx   <= idx + 3'd1;
                     if (last_bit) state <= bus.parity_en ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     par_bit <= bit_v;
                     state   <= STOP;
                  end
               end
               STOP: begin
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd15) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end

         // A commit outranks a coincident read; overflow only rises on unread data.
         if (stop_done) begin
            bus.rx_data     <= frame_data;
            bus.rx_ready    <= 1'b1;
            bus.parity_err  <= bus.parity_en &
                               parity_fail(frame_data, par_bit, bus.parity_odd0_even1);
            bus.framing_err <= ~bit_v;
            if (bus.rx_ready && !bus.rx_data_read) bus.overflow <= 1'b1;
         end else if (bus.rx_data_read) begin
            bus.rx_ready    <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.framing_err <= 1'b0;
            bus.overflow    <= 1'b0;
         end
      end
   end
endmodule
